// File: rtl/alu_pkg.sv
// Shared ALU operation codes, default widths and the operand bundle layout.
package alu_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH     = 32;
  localparam int unsigned DEFAULT_ADDRESS_WIDTH  = 5;
  localparam int unsigned DEFAULT_ALU_CTRL_WIDTH = 3;

  localparam logic [DEFAULT_ALU_CTRL_WIDTH-1:0] ALU_ADD = 3'b000;
  localparam logic [DEFAULT_ALU_CTRL_WIDTH-1:0] ALU_SUB = 3'b001;
  localparam logic [DEFAULT_ALU_CTRL_WIDTH-1:0] ALU_AND = 3'b010;
  localparam logic [DEFAULT_ALU_CTRL_WIDTH-1:0] ALU_OR  = 3'b011;
  localparam logic [DEFAULT_ALU_CTRL_WIDTH-1:0] ALU_SLT = 3'b100;

  // Operand bundle handed to the ALU stage.
  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0]     op1;
    logic [DEFAULT_DATA_WIDTH-1:0]     op2;
    logic [DEFAULT_ALU_CTRL_WIDTH-1:0] ctrl;
    logic [DEFAULT_ADDRESS_WIDTH-1:0]  rd;
    logic                              reg_write;
  } of_bundle_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side fields, write-back path and ALU-side bundle of the operand fetch stage.
// master: the environment (decode, write-back, ALU); slave: the operand fetch stage.
interface operand_fetch_if import alu_pkg::*; #(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned ALU_CTRL_WIDTH = DEFAULT_ALU_CTRL_WIDTH
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [ADDRESS_WIDTH-1:0]  rs1;
  logic [ADDRESS_WIDTH-1:0]  rs2;
  logic [ADDRESS_WIDTH-1:0]  rd;
  logic                      ALUsrc;
  logic [DATA_WIDTH-1:0]     ImmOp;
  logic [ALU_CTRL_WIDTH-1:0] ALUctrl_in;
  logic                      RegWrite_in;

  logic                      wb_en;
  logic [ADDRESS_WIDTH-1:0]  wb_addr;
  logic [DATA_WIDTH-1:0]     wb_data;

  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     ALUop1;
  logic [DATA_WIDTH-1:0]     ALUop2;
  logic [ALU_CTRL_WIDTH-1:0] ALUctrl;
  logic [ADDRESS_WIDTH-1:0]  rd_out;
  logic                      RegWrite_out;

  logic [DATA_WIDTH-1:0]     a0;

  modport master (
    output in_valid, rs1, rs2, rd, ALUsrc, ImmOp, ALUctrl_in, RegWrite_in,
    output wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, ALUop1, ALUop2, ALUctrl, rd_out, RegWrite_out, a0
  );

  modport slave (
    input  in_valid, rs1, rs2, rd, ALUsrc, ImmOp, ALUctrl_in, RegWrite_in,
    input  wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, ALUop1, ALUop2, ALUctrl, rd_out, RegWrite_out, a0
  );

endinterface

// File: rtl/operand_fetch_reg_file.sv
// Register file: two combinational read ports with write-back bypass, one synchronous
// write port, x0 hardwired to zero, and a tap on x10 (a0).
module reg_file import alu_pkg::*; #(
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0]    rs1_data,
  output logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic                     wb_en,
  input  logic [ADDRESS_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int unsigned NumRegs = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NumRegs];
  logic                  wr_hit;

  assign wr_hit = wb_en && (wb_addr != '0);

  // Array write; x0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Reads see a same-cycle write-back to the same index; x0 always reads zero.
  always_comb begin
    rs1_data = regs[rs1];
    rs2_data = regs[rs2];
    if (wr_hit && (wb_addr == rs1)) rs1_data = wb_data;
    if (wr_hit && (wb_addr == rs2)) rs2_data = wb_data;
    if (rs1 == '0) rs1_data = '0;
    if (rs2 == '0) rs2_data = '0;
  end

  assign a0 = regs[10];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register file read, operand-2 select, and one valid/ready
// pipeline register holding the bundle for the ALU.
module operand_fetch import alu_pkg::*; #(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned ALU_CTRL_WIDTH = DEFAULT_ALU_CTRL_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  operand_fetch_if.slave  bus
);

  logic [DATA_WIDTH-1:0]     rs1_data;
  logic [DATA_WIDTH-1:0]     rs2_data;
  logic [DATA_WIDTH-1:0]     op2;
  logic                      load;

  logic                      valid_q;
  logic [DATA_WIDTH-1:0]     op1_q;
  logic [DATA_WIDTH-1:0]     op2_q;
  logic [ALU_CTRL_WIDTH-1:0] ctrl_q;
  logic [ADDRESS_WIDTH-1:0]  rd_q;
  logic                      reg_write_q;

  reg_file #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .rs1      (bus.rs1),
    .rs2      (bus.rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wb_en    (bus.wb_en),
    .wb_addr  (bus.wb_addr),
    .wb_data  (bus.wb_data),
    .a0       (bus.a0)
  );

  // Operand select and handshake decode.
  always_comb begin
    op2          = bus.ALUsrc ? bus.ImmOp : rs2_data;
    bus.in_ready = !valid_q || bus.out_ready;
    load         = bus.in_valid && bus.in_ready;
  end

  // Pipeline register: capture on load, drain when the ALU takes the bundle, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      ctrl_q      <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else if (load) begin
      valid_q     <= 1'b1;
      op1_q       <= rs1_data;
      op2_q       <= op2;
      ctrl_q      <= bus.ALUctrl_in;
      rd_q        <= bus.rd;
      reg_write_q <= bus.RegWrite_in;
    end else if (bus.out_ready) begin
      valid_q     <= 1'b0;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.ALUop1       = op1_q;
  assign bus.ALUop2       = op2_q;
  assign bus.ALUctrl      = ctrl_q;
  assign bus.rd_out       = rd_q;
  assign bus.RegWrite_out = reg_write_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a behavioural model (register array plus one
// held bundle) checked every cycle, and literal expectations at key points.
module tb_operand_fetch;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  operand_fetch_if bus ();

  operand_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [32];
  logic        m_valid;
  of_bundle_t  m_b;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_valid <= 1'b0;
      m_b     <= '0;
    end else begin
      if (bus.in_valid && (!m_valid || bus.out_ready)) begin
        m_valid     <= 1'b1;
        m_b.op1       <= m_read(bus.rs1);
        m_b.op2       <= bus.ALUsrc ? bus.ImmOp : m_read(bus.rs2);
        m_b.ctrl      <= bus.ALUctrl_in;
        m_b.rd        <= bus.rd;
        m_b.reg_write <= bus.RegWrite_in;
      end else if (bus.out_ready) begin
        m_valid <= 1'b0;
      end
      if (bus.wb_en && bus.wb_addr != 5'd0) m_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, (!m_valid || bus.out_ready)});
      check("a0", bus.a0, m_regs[10]);
      if (m_valid) begin
        check("ALUop1", bus.ALUop1, m_b.op1);
        check("ALUop2", bus.ALUop2, m_b.op2);
        check("ALUctrl", {29'd0, bus.ALUctrl}, {29'd0, m_b.ctrl});
        check("rd_out", {27'd0, bus.rd_out}, {27'd0, m_b.rd});
        check("RegWrite_out", {31'd0, bus.RegWrite_out}, {31'd0, m_b.reg_write});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] d, input logic src, input logic [31:0] imm,
                        input logic [2:0] ctrl, input logic rw);
    bus.in_valid    = v;
    bus.rs1         = r1;
    bus.rs2         = r2;
    bus.rd          = d;
    bus.ALUsrc      = src;
    bus.ImmOp       = imm;
    bus.ALUctrl_in  = ctrl;
    bus.RegWrite_in = rw;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.wb_en   = en;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  initial begin
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 3'd0, 1'b0);
    set_wb(1'b0, 5'd0, 32'd0);
    bus.out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset ALUop1", bus.ALUop1, 32'd0);
    step();

    // Write x5 then read it.
    set_wb(1'b1, 5'd5, 32'h0000_00AA);
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    set_in(1'b1, 5'd5, 5'd0, 5'd3, 1'b0, 32'd0, ALU_ADD, 1'b1);
    step();
    check("t2 ALUop1", bus.ALUop1, 32'h0000_00AA);
    check("t2 ALUop2", bus.ALUop2, 32'd0);
    check("t2 rd_out", {27'd0, bus.rd_out}, 32'd3);

    // Same-cycle write-back bypass into the captured bundle.
    set_wb(1'b1, 5'd7, 32'h0000_1234);
    set_in(1'b1, 5'd7, 5'd5, 5'd4, 1'b0, 32'd0, ALU_SUB, 1'b1);
    step();
    check("t3 ALUop1 bypass", bus.ALUop1, 32'h0000_1234);
    check("t3 ALUop2", bus.ALUop2, 32'h0000_00AA);

    // x0 write is discarded, and no bypass on x0 either.
    set_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 3'd0, 1'b0);
    step();
    set_in(1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 32'd0, ALU_AND, 1'b0);
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    check("t4 ALUop1 x0", bus.ALUop1, 32'd0);
    check("t4 ALUop2 x0", bus.ALUop2, 32'd0);

    // Backpressure: hold for 3 cycles; a write-back during the stall must not refresh.
    set_in(1'b1, 5'd7, 5'd0, 5'd9, 1'b0, 32'd0, ALU_AND, 1'b1);
    step();
    bus.out_ready = 1'b0;
    set_in(1'b1, 5'd5, 5'd7, 5'd12, 1'b0, 32'd0, ALU_OR, 1'b0);
    set_wb(1'b1, 5'd7, 32'h0000_0055);
    for (int i = 0; i < 3; i++) begin
      step();
      set_wb(1'b0, 5'd0, 32'd0);
      check("t5 in_ready stall", {31'd0, bus.in_ready}, 32'd0);
      check("t5 ALUop1 held", bus.ALUop1, 32'h0000_1234);
      check("t5 rd_out held", {27'd0, bus.rd_out}, 32'd9);
    end
    bus.out_ready = 1'b1;
    step();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 3'd0, 1'b0);
    check("t5 pending ALUop1", bus.ALUop1, 32'h0000_00AA);
    check("t5 pending ALUop2", bus.ALUop2, 32'h0000_0055);
    check("t5 pending rd_out", {27'd0, bus.rd_out}, 32'd12);
    step();
    check("t5 drained", {31'd0, bus.out_valid}, 32'd0);

    // Back-to-back issue with writes interleaved.
    for (int i = 1; i <= 6; i++) begin
      set_wb(1'b1, 5'(i + 10), 32'h100 * i);
      set_in(1'b1, 5'(i + 10), 5'(i + 9), 5'(i), 1'b0, 32'd0, 3'(i), i[0]);
      step();
    end
    set_wb(1'b0, 5'd0, 32'd0);
    check("b2b last ALUop1", bus.ALUop1, 32'h0000_0600);
    check("b2b last ALUop2", bus.ALUop2, 32'h0000_0500);

    // Immediate select, write to a0, and an out-of-range ALU code passing through.
    set_wb(1'b1, 5'd10, 32'd3);
    set_in(1'b1, 5'd5, 5'd7, 5'd2, 1'b1, 32'hFFFF_FFFC, ALU_SUB, 1'b1);
    step();
    set_wb(1'b0, 5'd0, 32'd0);
    check("t6 ALUop2 imm", bus.ALUop2, 32'hFFFF_FFFC);
    check("t6 ALUctrl", {29'd0, bus.ALUctrl}, 32'd1);
    check("t6 a0", bus.a0, 32'd3);
    set_in(1'b1, 5'd10, 5'd0, 5'd2, 1'b0, 32'd0, 3'b111, 1'b0);
    step();
    check("t6 ALUctrl 111", {29'd0, bus.ALUctrl}, 32'd7);
    check("t6 ALUop1 a0", bus.ALUop1, 32'd3);

    // Reset mid-stream with a held bundle.
    bus.out_ready = 1'b0;
    set_in(1'b1, 5'd5, 5'd0, 5'd1, 1'b0, 32'd0, 3'd0, 1'b1);
    step();
    rst = 1'b1;
    #1;
    check("t1 out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t1 a0", bus.a0, 32'd0);
    check("t1 in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("t1 ALUop1", bus.ALUop1, 32'd0);
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 1; i < 32; i++) begin
      set_in(1'b1, 5'(i), 5'(i), 5'(i), 1'b0, 32'd0, 3'd0, 1'b0);
      step();
      check("t1 reg zero op1", bus.ALUop1, 32'd0);
      check("t1 reg zero op2", bus.ALUop2, 32'd0);
    end
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 3'd0, 1'b0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
